// File: rtl/ap_sched_pkg.sv
// Shared types and default sizing for the ap_ctrl_chain request scheduler.
package ap_sched_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_TIMEOUT = 1024;
    localparam int unsigned TXN_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request after the last grant, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] gnt_oh_c,
    output logic [IW-1:0]      gnt_idx_c,
    output logic               gnt_any_c
);

    int unsigned idx;

    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_i) + k) % NUM_REQ;
            if (!gnt_any_c && req_i[IW'(idx)]) begin
                gnt_any_c             = 1'b1;
                gnt_idx_c             = IW'(idx);
                gnt_oh_c[IW'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ap_ctrl_scheduler.sv
// Shares one ap_ctrl_chain kernel among NUM_REQ requesters, one transaction at a time,
// with a per-transaction watchdog and a completed-transaction counter.
module ap_ctrl_scheduler
    import ap_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DW-1:0]      req_arg,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DW-1:0]              rsp_data,
    output logic                       rsp_err,
    input  logic                       rsp_ready,
    output logic                       ap_start,
    output logic                       ap_continue,
    input  logic                       ap_ready,
    input  logic                       ap_done,
    output logic [DW-1:0]              ap_arg,
    input  logic [DW-1:0]              ap_return,
    output logic                       busy,
    output logic [TXN_W-1:0]           txn_count
);

    localparam int unsigned IW   = $clog2(NUM_REQ);
    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        id_q, id_d;
    logic [DW-1:0]        arg_q, arg_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 err_q, err_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [TXN_W-1:0]     txn_count_q, txn_count_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 start_q, start_d;
    logic                 rspv_q, rspv_d;
    logic                 busy_q, busy_d;

    logic                 run;
    logic                 done_now;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic [DW-1:0]        arg_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_oh_c  (gnt_oh),
        .gnt_idx_c (gnt_idx),
        .gnt_any_c (gnt_any)
    );

    // Reset release is resynchronised; the FSM may only grant once it has propagated.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) sync_q <= 2'b00;
        else           sync_q <= {sync_q[0], 1'b1};
    end

    assign run = sync_q[1];

    always_comb begin
        arg_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == IW'(i)) arg_sel = req_arg[i*DW +: DW];
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        arg_d       = arg_q;
        data_d      = data_q;
        err_d       = err_q;
        wd_d        = wd_q;
        txn_count_d = txn_count_q;
        ack_d       = '0;
        done_now    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run && gnt_any) begin
                    state_d = ST_START;
                    last_d  = gnt_idx;
                    id_d    = gnt_idx;
                    arg_d   = arg_sel;
                    ack_d   = gnt_oh;
                    wd_d    = '0;
                    err_d   = 1'b0;
                end
            end
            ST_START, ST_WAIT_DONE: begin
                // A completion seen on the last watchdog cycle still wins over expiry.
                done_now = (state_q == ST_START) ? (ap_ready && ap_done) : ap_done;
                if (done_now) begin
                    state_d = ST_RESP;
                    data_d  = ap_return;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (state_q == ST_START && ap_ready) state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    txn_count_d = txn_count_q + TXN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        start_d = (state_d == ST_START);
        rspv_d  = (state_d == ST_RESP);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            id_q        <= '0;
            arg_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
            txn_count_q <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            rspv_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            arg_q       <= arg_d;
            data_q      <= data_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            txn_count_q <= txn_count_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            rspv_q      <= rspv_d;
            busy_q      <= busy_d;
        end
    end

    // ap_continue mirrors rsp_ready in the same cycle so the kernel releases with the handshake.
    assign ap_continue = (state_q == ST_RESP) && rsp_ready;

    assign req_ack   = ack_q;
    assign rsp_valid = rspv_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign ap_start  = start_q;
    assign ap_arg    = arg_q;
    assign busy      = busy_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_ap_ctrl_scheduler.sv
// Self-checking bench for ap_ctrl_scheduler: constant vector table, corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_ap_ctrl_scheduler;

    localparam int NR  = 4;
    localparam int DWL = 32;
    localparam int TO  = 16;
    localparam int NEVER = 99;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DWL-1:0] req_arg;
    logic [NR-1:0]     req_ack;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DWL-1:0]    rsp_data;
    logic              rsp_err;
    logic              rsp_ready;
    logic              ap_start;
    logic              ap_continue;
    logic              ap_ready;
    logic              ap_done;
    logic [DWL-1:0]    ap_arg;
    logic [DWL-1:0]    ap_return;
    logic              busy;
    logic [15:0]       txn_count;

    int checks = 0;
    int errors = 0;
    int        last_g;
    logic [15:0] cnt_m;

    always #5 ap_clk = ~ap_clk;

    ap_ctrl_scheduler #(.NUM_REQ(NR), .DW(DWL), .TIMEOUT(TO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_arg(req_arg), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .ap_start(ap_start), .ap_continue(ap_continue), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_arg(ap_arg), .ap_return(ap_return),
        .busy(busy), .txn_count(txn_count)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ack"},   64'(req_ack), 0);
        chk({nm, "_rspv"},  64'(rsp_valid), 0);
        chk({nm, "_rspid"}, 64'(rsp_id), 0);
        chk({nm, "_data"},  64'(rsp_data), 0);
        chk({nm, "_err"},   64'(rsp_err), 0);
        chk({nm, "_start"}, 64'(ap_start), 0);
        chk({nm, "_cont"},  64'(ap_continue), 0);
        chk({nm, "_busy"},  64'(busy), 0);
        chk({nm, "_cnt"},   64'(txn_count), 0);
        chk({nm, "_arg"},   64'(ap_arg), 0);
    endtask

    // Drives one request through the kernel; called and returns at a falling edge.
    task automatic run_txn(input logic [3:0] mask, input logic [31:0] base, input int rdy,
                           input int dn, input logic [31:0] ret, input int hold,
                           output logic [3:0] ack, output logic [31:0] arg, output int id,
                           output logic [31:0] data, output logic err, output int lat,
                           output int glat, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < NR; i++) req_arg[i*DWL +: DWL] = base + 32'(i);
        ap_return = ret;
        req_valid = mask;
        @(negedge ap_clk);
        glat = 1;
        while (req_ack == '0 && glat < 20) begin
            @(negedge ap_clk);
            glat++;
        end
        ack = req_ack;
        arg = ap_arg;
        req_valid = '0;
        id = -1; data = '0; err = 1'b0; lat = -1;
        if (ack == '0) begin
            ok = 1'b0;
            return;
        end
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (ap_start !== (lat <= rdy)) ok = 1'b0;
            if (ap_arg !== arg) ok = 1'b0;
            if (lat > 0 && req_ack != '0) ok = 1'b0;
            ap_ready = (lat == rdy);
            ap_done  = (lat == dn);
            @(negedge ap_clk);
            lat++;
            ap_ready = 1'b0;
            ap_done  = 1'b0;
        end
        if (!rsp_valid || ap_start || ap_arg !== arg) ok = 1'b0;
        id   = int'(rsp_id);
        data = rsp_data;
        err  = rsp_err;
        req_valid = (hold > 0) ? 4'b1111 : 4'b0000;
        for (int h = 0; h < hold; h++) begin
            if (!rsp_valid || rsp_data !== data || ap_continue || req_ack != '0) ok = 1'b0;
            @(negedge ap_clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        if (!ap_continue) ok = 1'b0;
        @(negedge ap_clk);
        rsp_ready = 1'b0;
        if (rsp_valid || busy) ok = 1'b0;
    endtask

    // Transaction-level model: round-robin after the last grant; done within the window wins.
    task automatic model_txn(input logic [3:0] mask, input int rdy, input int dn, input int hold,
                             input int exp_glat, input string nm);
        logic [31:0] base, ret, data, arg, edata;
        logic [3:0]  ack;
        logic        err, eerr, ok;
        int          id, lat, glat, eid, elat;
        base = $urandom;
        ret  = $urandom;
        eid  = -1;
        for (int k = 1; k <= NR; k++) begin
            if (eid < 0 && mask[(last_g + k) % NR]) eid = (last_g + k) % NR;
        end
        if (dn >= rdy && dn < TO) begin
            elat = dn + 1; eerr = 1'b0; edata = ret;
        end else begin
            elat = TO; eerr = 1'b1; edata = '0;
        end
        run_txn(mask, base, rdy, dn, ret, hold, ack, arg, id, data, err, lat, glat, ok);
        cnt_m = cnt_m + 16'd1;
        last_g = eid;
        chk({nm, "_ack"},  64'(ack), 64'(1 << eid));
        chk({nm, "_id"},   64'(id), 64'(eid));
        chk({nm, "_arg"},  64'(arg), 64'(base + 32'(eid)));
        chk({nm, "_data"}, 64'(data), 64'(edata));
        chk({nm, "_err"},  64'(err), 64'(eerr));
        chk({nm, "_lat"},  64'(lat), 64'(elat));
        chk({nm, "_glat"}, 64'(glat), 64'(exp_glat));
        chk({nm, "_proto"}, 64'(ok), 1);
        chk({nm, "_cnt"},  64'(txn_count), 64'(cnt_m));
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] base;
        int          rdy;
        int          dn;
        logic [31:0] ret;
        int          hold;
        int          exp_id;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [3:0]  ack;
        logic [31:0] arg, data;
        logic        err, ok;
        int          id, lat, glat, n, nacks, prev, gap_bad;
        logic        bad;

        tbl[0]  = '{4'b0001, 32'h5,     2,     2,     32'h6,      0, 0, 32'h6,      1'b0, 3};
        tbl[1]  = '{4'b1111, 32'h100,   0,     0,     32'h11,     0, 1, 32'h11,     1'b0, 1};
        tbl[2]  = '{4'b1111, 32'h200,   0,     0,     32'h22,     0, 2, 32'h22,     1'b0, 1};
        tbl[3]  = '{4'b1111, 32'h300,   0,     0,     32'h33,     0, 3, 32'h33,     1'b0, 1};
        tbl[4]  = '{4'b1111, 32'h400,   0,     0,     32'h44,     0, 0, 32'h44,     1'b0, 1};
        tbl[5]  = '{4'b1111, 32'h500,   0,     0,     32'h55,     0, 1, 32'h55,     1'b0, 1};
        tbl[6]  = '{4'b1010, 32'h600,   1,     3,     32'hABCD,   5, 3, 32'hABCD,   1'b0, 4};
        tbl[7]  = '{4'b0110, 32'h700,   0,     NEVER, 32'hDEAD,   0, 1, 32'h0,      1'b1, TO};
        tbl[8]  = '{4'b1000, 32'h800,   NEVER, NEVER, 32'hBEEF,   0, 3, 32'h0,      1'b1, TO};
        tbl[9]  = '{4'b0101, 32'h900,   0,     TO-1,  32'h1234,   0, 0, 32'h1234,   1'b0, TO};
        tbl[10] = '{4'b0100, 32'hA00,   3,     5,     32'h5555,   0, 2, 32'h5555,   1'b0, 6};
        tbl[11] = '{4'b1001, 32'hB00,   0,     0,     32'h7777,   2, 3, 32'h7777,   1'b0, 1};

        ap_rst_n = 1'b0; req_valid = '0; req_arg = '0; rsp_ready = 1'b0;
        ap_ready = 1'b0; ap_done = 1'b0; ap_return = '0;
        repeat (3) @(negedge ap_clk);
        chk_all_zero("reset");
        ap_rst_n = 1'b1;
        repeat (4) @(negedge ap_clk);

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].mask, tbl[i].base, tbl[i].rdy, tbl[i].dn, tbl[i].ret, tbl[i].hold,
                    ack, arg, id, data, err, lat, glat, ok);
            chk($sformatf("tbl%0d_ack", i),  64'(ack), 64'(1 << tbl[i].exp_id));
            chk($sformatf("tbl%0d_id", i),   64'(id), 64'(tbl[i].exp_id));
            chk($sformatf("tbl%0d_arg", i),  64'(arg), 64'(tbl[i].base + 32'(tbl[i].exp_id)));
            chk($sformatf("tbl%0d_data", i), 64'(data), 64'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_err", i),  64'(err), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_lat", i),  64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_glat", i), 64'(glat), 1);
            chk($sformatf("tbl%0d_proto", i), 64'(ok), 1);
            chk($sformatf("tbl%0d_cnt", i),  64'(txn_count), 64'(i + 1));
        end
        last_g = tbl[11].exp_id;
        cnt_m  = 16'd12;

        // Back-to-back with an immediate kernel: one grant every 3 cycles.
        req_valid = 4'b0001; ap_ready = 1'b1; ap_done = 1'b1; rsp_ready = 1'b1;
        nacks = 0; prev = -1; gap_bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge ap_clk);
            if (req_ack != '0) begin
                if (prev >= 0 && k - prev != 3) gap_bad++;
                prev = k;
                nacks++;
            end
        end
        req_valid = '0;
        repeat (3) @(negedge ap_clk);
        ap_ready = 1'b0; ap_done = 1'b0; rsp_ready = 1'b0;
        cnt_m = cnt_m + 16'(nacks);
        last_g = 0;
        chk("b2b_acks", 64'(nacks), 4);
        chk("b2b_gap", 64'(gap_bad), 0);
        chk("b2b_cnt", 64'(txn_count), 64'(16'd16));

        // Idle with no request and a stray kernel done: nothing moves.
        ap_done = 1'b1; ap_ready = 1'b1; bad = 1'b0;
        repeat (5) begin
            @(negedge ap_clk);
            if (req_ack != '0 || busy || rsp_valid || ap_start) bad = 1'b1;
        end
        ap_done = 1'b0; ap_ready = 1'b0;
        chk("idle_quiet", 64'(bad), 0);
        model_txn(4'b1111, 0, 1, 0, 1, "after_idle");

        // Reset asserted while waiting on the kernel.
        req_arg[DWL +: DWL] = 32'hCAFE_0001;
        req_valid = 4'b0010;
        @(negedge ap_clk);
        n = 1;
        while (req_ack == '0 && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        chk("rst_seq_ack", 64'(req_ack), 64'(4'b0010));
        req_valid = '0; ap_ready = 1'b1;
        @(negedge ap_clk);
        ap_ready = 1'b0;
        chk("rst_seq_busy", 64'(busy), 1);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        ap_done = 1'b1;
        @(negedge ap_clk);
        ap_done = 1'b0;
        chk("midrst_norsp", 64'(rsp_valid), 0);
        ap_rst_n = 1'b1;
        last_g = NR - 1;
        cnt_m  = 16'd0;
        model_txn(4'b1111, 0, 0, 0, 3, "post_rst");

        for (int r = 0; r < 40; r++) begin
            int rdy, dn;
            logic [3:0] m;
            m   = 4'($urandom_range(1, 15));
            rdy = $urandom_range(0, 3);
            dn  = ($urandom_range(0, 7) == 0) ? NEVER : rdy + $urandom_range(0, 4);
            model_txn(m, rdy, dn, $urandom_range(0, 2), 1, $sformatf("rnd%0d", r));
        end

        // Counter wrap: preload the count, then complete one more transaction.
        force dut.txn_count_q = 16'hFFFF;
        @(negedge ap_clk);
        release dut.txn_count_q;
        @(negedge ap_clk);
        chk("wrap_pre", 64'(txn_count), 64'(16'hFFFF));
        cnt_m = 16'hFFFF;
        model_txn(4'b0100, 0, 0, 0, 1, "wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ap_ctrl_scheduler.md
AP_CTRL_SCHEDULER -- requirements
Module: ap_ctrl_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ap_ctrl_chain kernel (2..8).
REQ-002 Parameter DW, default 32: argument/return width.
REQ-003 Parameter TIMEOUT, default 1024: watchdog limit in cycles per kernel transaction.
REQ-004 ap_clk  in  1  sole clock; all logic rising-edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester request, held until req_ack.
REQ-007 req_arg  in  NUM_REQ*DW  packed arguments, slice i belongs to requester i.
REQ-008 req_ack  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
REQ-009 rsp_valid  out  1  result available; rsp_id  out  clog2(NUM_REQ)  owner; rsp_data  out  DW  result; rsp_err  out  1  watchdog expiry.
REQ-010 rsp_ready  in  1  owner accepts result.
REQ-011 ap_start / ap_continue  out  1 each; ap_ready / ap_done  in  1 each; ap_arg  out  DW; ap_return  in  DW: kernel control/data.
REQ-012 busy  out  1  state != IDLE; txn_count  out  16  completed transactions.

Function
REQ-013 FSM states IDLE, START, WAIT_DONE, RESP; one transaction in flight max.
REQ-014 IDLE: if any req_valid, grant round-robin starting at (last_grant+1) mod NUM_REQ; latch index and req_arg slice into ap_arg; pulse req_ack[index]; next START.
REQ-015 IDLE with no req_valid: stay; last_grant unchanged.
REQ-016 START: ap_start=1 held until ap_ready sampled high; ap_ready&&ap_done same cycle -> latch ap_return, go RESP; ap_ready alone -> WAIT_DONE.
REQ-017 WAIT_DONE: ap_start=0; ap_done -> latch ap_return into rsp_data, go RESP.
REQ-018 ap_arg stable from START entry until RESP exit.
REQ-019 RESP: rsp_valid=1, rsp_id=granted index; ap_continue = rsp_ready; rsp_ready -> IDLE, txn_count+1 (wraps 0xFFFF->0).
REQ-020 Watchdog: cleared on START entry, increments each cycle in START/WAIT_DONE; reaching TIMEOUT-1 -> RESP with rsp_err=1, rsp_data=0, ap_start dropped.
REQ-021 rsp_err cleared on next START entry; errored transactions still count.
REQ-022 ap_done arriving outside START/WAIT_DONE ignored.
REQ-023 Grant latency: req_valid high in IDLE -> req_ack next edge-registered, ap_start high the following cycle (1 cycle).
REQ-024 Minimum back-to-back period: IDLE->START->RESP->IDLE = 3 cycles with ready/done/rsp_ready immediate.

Reset
REQ-025 ap_rst_n low: state IDLE, all outputs 0 (ap_start, ap_continue, req_ack, rsp_*, busy, txn_count, ap_arg), last_grant = NUM_REQ-1, watchdog 0.
REQ-026 Reset mid-transaction aborts it immediately; no response issued; kernel restarts cleanly after release.
REQ-027 Deassertion synchronised internally (two-flop) before FSM leaves IDLE.

Structure
REQ-028 Shared package ap_sched_pkg: state enum, default NUM_REQ/DW/TIMEOUT constants.
REQ-029 One sub-module rr_arbiter (request vector + last_grant -> one-hot grant, index); FSM, watchdog, counters in top.

Verification
REQ-030 req_valid=4'b0001, arg 0x5, kernel ready+done cycle 2, return 0x6 -> req_ack[0] pulse, rsp_id=0, rsp_data=0x6, rsp_err=0, txn_count=1.
REQ-031 req_valid=4'b1111 held, immediate kernel -> grants in order 0,1,2,3,0; no requester starved.
REQ-032 ap_done never asserted, TIMEOUT=16 -> rsp_valid with rsp_err=1, rsp_data=0 exactly 16 cycles after START entry.
REQ-033 rsp_ready low 5 cycles -> rsp_valid/rsp_data held, ap_continue 0, no new req_ack.
REQ-034 ap_rst_n low during WAIT_DONE -> all outputs 0 asynchronously, no rsp_valid; next request served normally.
REQ-035 Preload txn_count 0xFFFF via 65535 transactions (or force) -> next completion gives 0x0000.
